// File: rtl/stream_mux_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : stream_mux_pkg                                             |
// | Brief   : Shared mode encodings and channel-index width helper for   |
// |           the stream select mux and its arbiter.                     |
// | Rev     : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Channel index width; a single channel still needs a 1-bit index.
  function automatic int calc_sel_w(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rr_arbiter                                                 |
// | Brief   : Combinational rotate-priority scan. Returns the first      |
// |           requesting index at or after ptr, wrapping at NUM_CH.      |
// | Rev     : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = calc_sel_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  gnt_idx,
  output logic              gnt_any
);

  // Scan offsets 0..NUM_CH-1 from ptr; the first hit wins.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      int w_idx;
      w_idx = (int'(ptr) + i) % NUM_CH;
      if (!gnt_any && req[w_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = SEL_W'(w_idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/stream_select_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : stream_select_mux                                          |
// | Brief   : Selects one of NUM_CH valid/ready streams (fixed select or |
// |           round-robin) into a single registered output stream.       |
// | Rev     : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module stream_select_mux
  import stream_mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = calc_sel_w(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch
);

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [SEL_W-1:0]  r_out_ch;
  logic [SEL_W-1:0]  r_rr_ptr;

  logic              w_slot_free;
  logic              w_fix_any;
  logic [SEL_W-1:0]  w_rr_idx;
  logic              w_rr_any;
  logic [SEL_W-1:0]  w_cand;
  logic              w_cand_any;
  logic [DATA_W-1:0] w_cand_data;
  logic              w_load;
  logic [SEL_W-1:0]  w_rr_next;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_arb (
    .req     (in_valid),
    .ptr     (r_rr_ptr),
    .gnt_idx (w_rr_idx),
    .gnt_any (w_rr_any)
  );

  // Fixed-mode candidate: an out-of-range sel matches no channel, so no transfer.
  always_comb begin
    w_fix_any = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel == SEL_W'(i)) w_fix_any = in_valid[i];
    end
  end

  assign w_slot_free = !r_out_valid || out_ready;
  assign w_cand      = (mode == MODE_RR) ? w_rr_idx : sel;
  assign w_cand_any  = (mode == MODE_RR) ? w_rr_any : w_fix_any;
  // Reset gating keeps every ready low while reset is held.
  assign w_load      = !reset && enable && w_slot_free && w_cand_any;
  assign w_rr_next   = (w_cand == SEL_W'(NUM_CH - 1)) ? '0 : w_cand + SEL_W'(1);

  // One-hot ready to the granted channel and data mux for the candidate.
  always_comb begin
    in_ready    = '0;
    w_cand_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_cand == SEL_W'(i)) begin
        in_ready[i] = w_load;
        w_cand_data = in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Output register and round-robin pointer; a load takes priority over draining.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_rr_ptr    <= '0;
    end else begin
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_cand_data;
        r_out_ch    <= w_cand;
        if (mode == MODE_RR) r_rr_ptr <= w_rr_next;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;

endmodule
`default_nettype wire

// File: tb/tb_stream_select_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_stream_select_mux                                       |
// | Brief   : Directed self-checking bench for stream_select_mux         |
// |           (NUM_CH=4, DATA_W=8).                                      |
// | Rev     : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_stream_select_mux;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;
  localparam int SEL_W  = 2;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     enable;
  logic                     mode;
  logic [SEL_W-1:0]         sel;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_ready;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic [SEL_W-1:0]         out_ch;

  int n_checks = 0;
  int n_fail   = 0;

  stream_select_mux #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and return at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b1;
    mode      = 1'b0;
    sel       = 2'd0;
    in_valid  = 4'hF;
    in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
    out_ready = 1'b0;
    step();
    step();
    // Reset state, with valid inputs present
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'h00);
    check("rst_out_ch",    32'(out_ch),    32'd0);
    check("rst_in_ready",  32'(in_ready),  32'h0);

    // Release with idle inputs
    in_valid = 4'h0;
    reset    = 1'b0;
    step();
    step();
    check("idle_out_valid", 32'(out_valid), 32'd0);

    // Fixed mode single transfer on ch2
    mode      = 1'b0;
    sel       = 2'd2;
    in_valid  = 4'b0100;
    in_data   = {8'h00, 8'hA5, 8'h00, 8'h00};
    out_ready = 1'b1;
    #1;
    check("fix_in_ready", 32'(in_ready), 32'b0100);
    step();
    check("fix_out_valid", 32'(out_valid), 32'd1);
    check("fix_out_data",  32'(out_data),  32'hA5);
    check("fix_out_ch",    32'(out_ch),    32'd2);
    // Valid on ch1 only while sel=2 must be ignored
    in_valid = 4'b0010;
    #1;
    check("fix_ignore_ch1", 32'(in_ready), 32'h0);
    step();
    check("fix_drain_valid", 32'(out_valid), 32'd0);
    check("fix_hold_data",   32'(out_data),  32'hA5);

    // Reset mid-transfer clears the output immediately
    in_valid = 4'b0100;
    step();
    check("mid_pre_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data",  32'(out_data),  32'h00);
    check("mid_rst_ch",    32'(out_ch),    32'd0);
    check("mid_rst_ready", 32'(in_ready),  32'h0);
    in_valid = 4'h0;
    @(negedge clk);
    reset = 1'b0;

    // Round-robin fairness, all channels valid
    mode     = 1'b1;
    in_valid = 4'hF;
    in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int k = 0; k < 6; k++) begin
      step();
      check("rr_out_ch",    32'(out_ch),    32'(k % 4));
      check("rr_out_data",  32'(out_data),  32'(8'h10 + (k % 4)));
      check("rr_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 4'h0;
    step();
    check("rr_drain_valid", 32'(out_valid), 32'd0);

    // rr_ptr is 2: grant ch2 to move it to 3, then skip/wrap with 0011
    in_valid = 4'b0100;
    step();
    check("wrap_pre_ch", 32'(out_ch), 32'd2);
    in_valid = 4'b0011;
    #1;
    check("wrap_ready0", 32'(in_ready), 32'b0001);
    step();
    check("wrap_ch0", 32'(out_ch), 32'd0);
    check("wrap_ready1", 32'(in_ready), 32'b0010);
    step();
    check("wrap_ch1", 32'(out_ch), 32'd1);
    check("wrap_data1", 32'(out_data), 32'h11);
    check("wrap_ready2", 32'(in_ready), 32'b0001);
    step();
    check("wrap_ch0b", 32'(out_ch), 32'd0);
    in_valid = 4'h0;
    step();

    // Backpressure in fixed mode on ch3 (rr_ptr stays 1)
    mode      = 1'b0;
    sel       = 2'd3;
    in_valid  = 4'b1000;
    in_data   = {8'h5C, 8'h00, 8'h00, 8'h00};
    out_ready = 1'b0;
    step();
    check("bp_load_data", 32'(out_data), 32'h5C);
    check("bp_load_ch",   32'(out_ch),   32'd3);
    in_data = {8'h77, 8'h00, 8'h00, 8'h00};
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_in_ready",  32'(in_ready),  32'h0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data",  32'(out_data),  32'h5C);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'b1000);
    step();
    check("bp_reload_valid", 32'(out_valid), 32'd1);
    check("bp_reload_data",  32'(out_data),  32'h77);
    in_valid = 4'h0;
    step();
    check("bp_final_drain", 32'(out_valid), 32'd0);

    // Enable gating: rr_ptr=1 so first RR grant is ch1, pointer then 2
    mode     = 1'b1;
    in_valid = 4'hF;
    in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    step();
    check("en_first_ch", 32'(out_ch), 32'd1);
    enable = 1'b0;
    #1;
    check("en_off_ready", 32'(in_ready), 32'h0);
    step();
    check("en_off_drain", 32'(out_valid), 32'd0);
    step();
    check("en_off_idle", 32'(out_valid), 32'd0);
    check("en_off_ready2", 32'(in_ready), 32'h0);
    enable = 1'b1;
    #1;
    check("en_on_ready", 32'(in_ready), 32'b0100);
    step();
    check("en_on_ch",   32'(out_ch),   32'd2);
    check("en_on_data", 32'(out_data), 32'h12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
